// File: rtl/lpif_tx_concat_param.sv
// LPIF TX concatenator: FIFO-buffered logic-link words packed into NUM_CH PHY
// channels with strobe/marker bits. Optional LPIF_TX_UNDERRUN_CNT_EN adds tx_underrun_cnt.

module lpif_tx_ch_pack #(
  parameter int CH_WIDTH = 80,
  parameter int STB_LOC  = 1,
  parameter int MRK_LOC  = 77
) (
  input  logic [CH_WIDTH-4:0] pl,
  input  logic                stb,
  input  logic                mrk,
  output logic [CH_WIDTH-1:0] word
);
  // Payload fills every bit except strobe, marker and the MSB, in ascending order.
  for (genvar b = 0; b < CH_WIDTH; b++) begin : g_bit
    if (b == STB_LOC) begin : g_stb
      assign word[b] = stb;
    end else if (b == MRK_LOC) begin : g_mrk
      assign word[b] = mrk;
    end else if (b == CH_WIDTH-1) begin : g_msb
      assign word[b] = 1'b0;
    end else begin : g_pl
      assign word[b] = pl[b - ((b > STB_LOC) ? 1 : 0) - ((b > MRK_LOC) ? 1 : 0)];
    end
  end
endmodule

module lpif_tx_concat_param #(
  parameter int NUM_CH      = 1,
  parameter int CH_WIDTH    = 80,
  parameter int STB_LOC     = 1,
  parameter int MRK_LOC     = 77,
  parameter int MRK_PERIOD  = 4,
  parameter int ALIGN_BEATS = 16,
  parameter int FIFO_DEPTH  = 4,
  localparam int USR_W      = CH_WIDTH-3,
  localparam int DW         = NUM_CH*USR_W
) (
  input  logic                       clk_wr,
  input  logic                       rst_wr,
  input  logic                       tx_online,
  input  logic                       tx_pause,
  input  logic [DW-1:0]              tx_data,
  input  logic                       tx_data_vld,
  output logic                       tx_data_rdy,
  output logic [NUM_CH*CH_WIDTH-1:0] tx_phy,
  output logic                       tx_aligned,
`ifdef LPIF_TX_UNDERRUN_CNT_EN
  output logic [15:0]                tx_underrun_cnt,
`endif
  output logic                       tx_fifo_empty
);
  localparam int PW = NUM_CH*CH_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MRK_PERIOD);
  localparam int CW = $clog2(ALIGN_BEATS+1);
  localparam logic [BW-1:0] MRK_LAST = BW'(MRK_PERIOD-1);
  localparam logic [CW-1:0] ALN_LAST = CW'(ALIGN_BEATS-1);

  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_ALN = 2'd1;
  localparam logic [1:0] ST_ACT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] aln_cnt_q, aln_cnt_d;
  logic [PW-1:0] phy_q, phy_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];

  logic          empty, full, beat, push, pop;
  logic [DW-1:0] payload;
  logic [NUM_CH-1:0][USR_W-1:0]    pl_ch;
  logic [NUM_CH-1:0][CH_WIDTH-1:0] word_ch;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign beat  = (state_q != ST_OFF) && !tx_pause;
  assign push  = tx_data_vld && tx_data_rdy;
  assign pop   = beat && (state_q == ST_ACT) && !empty;

  assign tx_data_rdy   = (state_q != ST_OFF) && !full;
  assign tx_aligned    = (state_q == ST_ACT);
  assign tx_fifo_empty = empty;
  assign tx_phy        = phy_q;

  assign payload = (state_q == ST_ACT && !empty) ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign pl_ch   = payload;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lpif_tx_ch_pack #(.CH_WIDTH(CH_WIDTH), .STB_LOC(STB_LOC), .MRK_LOC(MRK_LOC)) u_pack (
      .pl  (pl_ch[c]),
      .stb (beat_cnt_q == '0),
      .mrk (beat_cnt_q == MRK_LAST),
      .word(word_ch[c])
    );
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    aln_cnt_d  = aln_cnt_q;
    phy_d      = phy_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (beat) begin
      phy_d      = word_ch;
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
    case (state_q)
      ST_OFF: if (tx_online) begin
        state_d   = ST_ALN;
        aln_cnt_d = '0;
      end
      ST_ALN: if (beat) begin
        aln_cnt_d = aln_cnt_q + 1'b1;
        if (aln_cnt_q == ALN_LAST) state_d = ST_ACT;
      end
      default: ;
    endcase
    // Dropping the link overrides everything and flushes queued words.
    if (!tx_online) begin
      state_d    = ST_OFF;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      beat_cnt_d = '0;
      aln_cnt_d  = '0;
      phy_d      = '0;
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state_q    <= ST_OFF;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      aln_cnt_q  <= '0;
      phy_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      aln_cnt_q  <= aln_cnt_d;
      phy_q      <= phy_d;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk_wr) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
  end

`ifdef LPIF_TX_UNDERRUN_CNT_EN
  logic [15:0] und_cnt_q, und_cnt_d;

  always_comb begin
    und_cnt_d = und_cnt_q;
    if (beat && state_q == ST_ACT && empty && und_cnt_q != 16'hFFFF)
      und_cnt_d = und_cnt_q + 16'd1;
    if (!tx_online || state_q == ST_OFF) und_cnt_d = '0;
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) und_cnt_q <= '0;
    else        und_cnt_q <= und_cnt_d;
  end

  assign tx_underrun_cnt = und_cnt_q;
`endif
endmodule
